// File: rtl/imm_pkg.sv
// Shared definitions for the RV immediate generator: format encodings and the
// combinational decode of instruction bits [31:7] into an extended immediate.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;

  // instr[k] here is instruction bit k+7. Result is {err, imm[63:0]}; callers
  // keep the low XLEN bits, which is the correct sign extension for 32 as well.
  function automatic logic [64:0] imm_decode(input logic [24:0] instr,
                                             input logic [2:0]  src,
                                             input int unsigned xlen);
    logic [63:0] imm;
    logic        err;
    imm = '0;
    err = 1'b0;
    case (src)
      IMM_I:     imm = {{52{instr[24]}}, instr[24:13]};
      IMM_S:     imm = {{52{instr[24]}}, instr[24:18], instr[4:0]};
      IMM_B:     imm = {{52{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_J:     imm = {{44{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_U:     imm = {{32{instr[24]}}, instr[24:5], 12'b0};
      IMM_SHAMT: imm = (xlen == 64) ? {58'b0, instr[18:13]} : {59'b0, instr[17:13]};
      default:   err = 1'b1;
    endcase
    return {err, imm};
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main output register plus one skid
// register, with in_ready taken directly from a flop.
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld;
  logic         skid_vld;
  logic         ready_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         deliver;

  assign accept    = in_valid & ready_q;
  assign deliver   = main_vld & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = main_vld;
  assign out_data  = main_q;

  // Main register refills from skid first so ordering stays FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b1;
      main_q   <= '0;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b1;
    end else if (!main_vld || deliver) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
        ready_q  <= 1'b1;
      end else begin
        main_vld <= accept;
        if (accept) main_q <= in_data;
      end
    end else if (accept) begin
      skid_vld <= 1'b1;
      ready_q  <= 1'b0;
    end
  end

  // Skid payload needs no reset; its contents are only observed when skid_vld is set.
  always_ff @(posedge clk) begin
    if (accept && main_vld && !deliver && !flush) skid_q <= in_data;
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered, handshaked immediate generator between decode and the ID/EX
// register: decodes on the input side and holds results in a 2-entry skid.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W = 1 + XLEN + TAG_W;

  logic [64:0]  dec;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;

  assign dec     = imm_decode(in_instr, in_src, XLEN);
  assign in_data = {dec[64], dec[XLEN-1:0], in_tag};

  if (XLEN < 64) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^dec[63:XLEN];
  end

  imm_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {out_err, out_imm, out_tag} = out_data;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench driving an XLEN=32 and an XLEN=64 instance with identical stimulus,
// checked against a queue-based reference model of the pipe.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [24:0] in_instr = '0;
  logic [2:0]  in_src = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        rdy32, vld32, err32, rdy64, vld64, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_err(err32), .out_tag(tag32));

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_src(in_src), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_err(err64), .out_tag(tag64));

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  typedef struct {
    logic [24:0] instr;
    logic [2:0]  src;
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  exp_t q[$];
  exp_t tbl_exp;
  bit   use_tbl = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate computed arithmetically from the full 32-bit instruction word.
  function automatic exp_t ref_model(input logic [24:0] hi, input logic [2:0] src,
                                     input logic [4:0] tag);
    exp_t        e;
    logic [31:0] i;
    longint      s;
    longint      v;
    i = {hi, 7'b0};
    s = longint'($signed(i));
    v = 0;
    e.err = 1'b0;
    e.tag = tag;
    case (src)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      3'd2: v = ((s >>> 31) <<< 12) | (longint'(i[7]) << 11) |
                (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      3'd3: v = ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12) |
                (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      3'd4: v = (s >>> 12) <<< 12;
      3'd5: v = 0;
      default: e.err = 1'b1;
    endcase
    e.i64 = v;
    e.i32 = e.i64[31:0];
    if (src == 3'd5) begin
      e.i64 = 64'(i[25:20]);
      e.i32 = 32'(i[24:20]);
    end
    return e;
  endfunction

  // Called at a negedge with inputs set; checks this cycle, advances the model.
  task automatic cycle();
    exp_t e;
    bit   acc;
    bit   del;
    acc = in_valid && (q.size() < 2);
    del = (q.size() > 0) && out_ready;
    chk("valid32", 64'(vld32), 64'(q.size() > 0));
    chk("valid64", 64'(vld64), 64'(q.size() > 0));
    chk("ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("ready64", 64'(rdy64), 64'(q.size() < 2));
    if (del) begin
      e = q.pop_front();
      chk("imm32", 64'(imm32), 64'(e.i32));
      chk("imm64", imm64, e.i64);
      chk("err32", 64'(err32), 64'(e.err));
      chk("err64", 64'(err64), 64'(e.err));
      chk("tag32", 64'(tag32), 64'(e.tag));
      chk("tag64", 64'(tag64), 64'(e.tag));
    end
    if (flush) q.delete();
    else if (acc) q.push_back(use_tbl ? tbl_exp : ref_model(in_instr, in_src, in_tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_reset(input string nm);
    chk({nm, "_valid32"}, 64'(vld32), 64'(0));
    chk({nm, "_valid64"}, 64'(vld64), 64'(0));
    chk({nm, "_imm32"}, 64'(imm32), 64'(0));
    chk({nm, "_imm64"}, imm64, 64'(0));
    chk({nm, "_err"}, 64'({err32, err64}), 64'(0));
    chk({nm, "_tag"}, 64'({tag32, tag64}), 64'(0));
    chk({nm, "_ready"}, 64'({rdy32, rdy64}), 64'(2'b11));
  endtask

  task automatic offer(input logic [2:0] src, input logic [4:0] tag);
    in_valid = 1'b1;
    in_instr = 25'($urandom);
    in_src   = src;
    in_tag   = tag;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{25'(32'hFFF00093 >> 7), 3'd0, 5'd1,  32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[1]  = '{25'(32'hFE20AE23 >> 7), 3'd1, 5'd2,  32'hFFFFFFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[2]  = '{25'(32'hFE000CE3 >> 7), 3'd2, 5'd3,  32'hFFFFFFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
    tbl[3]  = '{25'(32'h0010006F >> 7), 3'd3, 5'd4,  32'h00000800, 64'h0000_0000_0000_0800, 1'b0};
    tbl[4]  = '{25'(32'h123450B7 >> 7), 3'd4, 5'd5,  32'h12345000, 64'h0000_0000_1234_5000, 1'b0};
    tbl[5]  = '{25'(32'h800000B7 >> 7), 3'd4, 5'd6,  32'h80000000, 64'hFFFF_FFFF_8000_0000, 1'b0};
    tbl[6]  = '{25'(32'h03F01013 >> 7), 3'd5, 5'd8,  32'h0000001F, 64'h0000_0000_0000_003F, 1'b0};
    tbl[7]  = '{25'(32'hFFFFFFFF >> 7), 3'd6, 5'd7,  32'h00000000, 64'h0000_0000_0000_0000, 1'b1};
    tbl[8]  = '{25'(32'h00500093 >> 7), 3'd0, 5'd9,  32'h00000005, 64'h0000_0000_0000_0005, 1'b0};
    tbl[9]  = '{25'(32'h12345678 >> 7), 3'd7, 5'd10, 32'h00000000, 64'h0000_0000_0000_0000, 1'b1};
    tbl[10] = '{25'(32'h00501013 >> 7), 3'd5, 5'd11, 32'h00000005, 64'h0000_0000_0000_0005, 1'b0};

    #1 reset = 1'b1;
    #2 check_idle_reset("reset");
    #4 reset = 1'b0;
    @(negedge clk);

    // Directed format vectors, one beat per cycle with out_ready high.
    use_tbl = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      in_src   = tbl[i].src;
      in_tag   = tbl[i].tag;
      tbl_exp  = '{tbl[i].e32, tbl[i].e64, tbl[i].err, tbl[i].tag};
      cycle();
    end
    use_tbl = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Backpressure: three beats offered while downstream stalls.
    out_ready = 1'b0;
    offer(3'd0, 5'd21); cycle();
    offer(3'd1, 5'd22); cycle();
    offer(3'd4, 5'd23);
    chk("bp_ready_low", 64'({rdy32, rdy64}), 64'(0));
    cycle(); cycle();
    out_ready = 1'b1;
    cycle(); cycle();
    in_valid = 1'b0;
    cycle(); cycle();

    // Flush with main and skid full and a beat offered.
    out_ready = 1'b0;
    offer(3'd2, 5'd24); cycle();
    offer(3'd3, 5'd25); cycle();
    offer(3'd0, 5'd26);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'({vld32, vld64}), 64'(0));
    chk("flush_ready", 64'({rdy32, rdy64}), 64'(2'b11));
    out_ready = 1'b1;
    cycle(); cycle();

    // Flush alongside a delivery and an accept: delivery counts, new beat is dropped.
    offer(3'd1, 5'd27); cycle();
    offer(3'd2, 5'd28);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    cycle(); cycle();

    // Asynchronous reset between clock edges with beats held.
    out_ready = 1'b0;
    offer(3'd3, 5'd29); cycle();
    offer(3'd4, 5'd30); cycle();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_idle_reset("async_reset");
    q.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    offer(3'd0, 5'd31); cycle();
    in_valid = 1'b0;
    chk("post_reset_latency", 64'({vld32, vld64}), 64'(2'b11));
    cycle(); cycle();

    // Randomized traffic with random stalls and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_instr  = 25'($urandom);
      in_src    = 3'($urandom % 8);
      in_tag    = 5'($urandom);
      flush     = ($urandom % 40) == 0;
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cycle(); cycle(); cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
